prog_stream_tx: RTL

- Host-side companion to the CPU core's byte-serial program loader and readback port.
- Buffers a program image written by the host, then drives the CPU's `instr_i` byte stream at one byte per clock, framed as `START_BYTE`, payload, padding and `END_BYTE`.
- After a fixed run window, scans the CPU's `address`/`vout_addr`/`DataOrReg` readback port and reassembles 32-bit words for the host.

---
 rtl/prog_stream_tx.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/prog_stream_tx.sv
// rtl/prog_stream_tx.sv - buffers a host program image, streams it to the CPU loader, then scans readback words
`ifndef INSTR_START
`define INSTR_START 8'hF0
`endif
`ifndef INSTR_END
`define INSTR_END 8'h0F
`endif

module prog_stream_tx #(
  parameter int         DEPTH      = 256,
  parameter int         MIN_GAP    = 124,
  parameter logic [7:0] START_BYTE = `INSTR_START,
  parameter logic [7:0] END_BYTE   = `INSTR_END,
  parameter logic [7:0] PAD_BYTE   = 8'h00,
  parameter int         RUN_CYCLES = 1024
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        wr_en_i,
  input  logic [7:0]  wr_data_i,
  output logic        wr_ready_o,
  input  logic        go_i,
  input  logic        scan_sel_i,
  input  logic [10:0] scan_count_i,
  output logic        cpu_reset_o,
  output logic [7:0]  instr_o,
  output logic [10:0] address_o,
  output logic [1:0]  vout_addr_o,
  output logic        data_or_reg_o,
  input  logic [7:0]  value_i,
  output logic        rd_valid_o,
  output logic [31:0] rd_word_o,
  output logic [10:0] rd_index_o,
  output logic        busy_o,
  output logic        collision_o
);
  localparam int AW   = $clog2(DEPTH);
  localparam int PW   = AW + 1;
  localparam int GMAX = (DEPTH > MIN_GAP) ? DEPTH : MIN_GAP;
  localparam int GW   = $clog2(GMAX + 1);
  localparam int RW   = $clog2(RUN_CYCLES + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_REL, S_START, S_PAYLOAD, S_PAD, S_END, S_RUN, S_SCAN_SET, S_SCAN_CAP
  } state_t;

  state_t          state, state_next;
  logic [7:0]      mem [DEPTH];
  logic [PW-1:0]   wr_ptr, len, len_eff;
  logic [GW-1:0]   g;
  logic [RW-1:0]   run_cnt;
  logic [10:0]     w, count_q;
  logic [1:0]      b;
  logic [23:0]     word;
  logic            sel_q;
  logic            buf_full, wr_accept, go_accept;
  logic            last_payload, run_done, last_word;
  logic [7:0]      cur_byte;

  assign buf_full     = (wr_ptr == PW'(DEPTH));
  assign wr_accept    = (state == S_IDLE) && wr_en_i && !buf_full;
  // A write in the same cycle as go counts toward the frame length.
  assign len_eff      = wr_ptr + PW'(wr_accept);
  assign go_accept    = (state == S_IDLE) && go_i && (len_eff != '0);
  assign cur_byte     = mem[g[AW-1:0]];
  assign last_payload = (g == GW'(len) - GW'(1));
  assign run_done     = (run_cnt == RW'(RUN_CYCLES - 1));
  assign last_word    = (w == count_q - 11'd1);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= S_IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:     if (go_accept) state_next = S_REL;
      S_REL:      state_next = S_START;
      S_START:    state_next = S_PAYLOAD;
      S_PAYLOAD:  if (last_payload) state_next = (int'(len) < MIN_GAP) ? S_PAD : S_END;
      S_PAD:      if (g == GW'(MIN_GAP - 1)) state_next = S_END;
      S_END:      state_next = S_RUN;
      S_RUN:      if (run_done) state_next = (count_q == 11'd0) ? S_IDLE : S_SCAN_SET;
      S_SCAN_SET: state_next = S_SCAN_CAP;
      S_SCAN_CAP: state_next = (b == 2'd3 && last_word) ? S_IDLE : S_SCAN_SET;
      default:    state_next = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ready_o = (state == S_IDLE) && !buf_full;
    busy_o     = (state != S_IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (wr_accept) mem[wr_ptr[AW-1:0]] <= wr_data_i;
  end

  // Registered outputs follow the current state, so each byte lands one cycle after state entry.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr        <= '0;
      len           <= '0;
      sel_q         <= 1'b0;
      count_q       <= '0;
      g             <= '0;
      run_cnt       <= '0;
      w             <= '0;
      b             <= '0;
      word          <= '0;
      cpu_reset_o   <= 1'b1;
      instr_o       <= PAD_BYTE;
      address_o     <= '0;
      vout_addr_o   <= '0;
      data_or_reg_o <= 1'b0;
      rd_valid_o    <= 1'b0;
      rd_word_o     <= '0;
      rd_index_o    <= '0;
      collision_o   <= 1'b0;
    end else begin
      rd_valid_o  <= 1'b0;
      instr_o     <= PAD_BYTE;
      cpu_reset_o <= (state == S_IDLE) || (state_next == S_IDLE);
      unique case (state)
        S_IDLE: begin
          if (wr_accept) wr_ptr <= wr_ptr + PW'(1);
          if (go_accept) begin
            len         <= len_eff;
            sel_q       <= scan_sel_i;
            count_q     <= scan_count_i;
            collision_o <= 1'b0;
          end
        end
        S_START: begin
          instr_o <= START_BYTE;
          g       <= '0;
        end
        S_PAYLOAD: begin
          instr_o <= cur_byte;
          g       <= g + GW'(1);
          if (cur_byte == END_BYTE && g > GW'(120)) collision_o <= 1'b1;
        end
        S_PAD: g <= g + GW'(1);
        S_END: begin
          instr_o <= END_BYTE;
          run_cnt <= '0;
        end
        S_RUN: begin
          run_cnt <= run_cnt + RW'(1);
          w       <= '0;
          b       <= '0;
        end
        S_SCAN_SET: begin
          address_o     <= w;
          vout_addr_o   <= b;
          data_or_reg_o <= sel_q;
        end
        S_SCAN_CAP: begin
          b <= b + 2'd1;
          case (b)
            2'd0: word[7:0]   <= value_i;
            2'd1: word[15:8]  <= value_i;
            2'd2: word[23:16] <= value_i;
            default: begin
              rd_word_o  <= {value_i, word};
              rd_index_o <= w;
              rd_valid_o <= 1'b1;
              w          <= w + 11'd1;
            end
          endcase
        end
        default: ;
      endcase
      if (state != S_IDLE && state_next == S_IDLE) wr_ptr <= '0;
    end
  end
endmodule
